// File: rtl/ps03_pkg.sv
// Shared types and constants for the ps03 stimulus generator.
package ps03_pkg;

   typedef enum logic [1:0] {
      MODE_LOOP   = 2'b00,
      MODE_SINGLE = 2'b01,
      MODE_RAND   = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Galois form of x^32 + x^22 + x^2 + x + 1, right-shifting.
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

   // The unused encoding 2'b11 runs as a single pass.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'b00:   return MODE_LOOP;
         2'b10:   return MODE_RAND;
         default: return MODE_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/ps03_stimgen_if.sv
// Vector stream from the stimulus generator to the consumer.
interface ps03_stimgen_if #(
   parameter int unsigned data_width = 32,
   parameter int unsigned op_width   = 4,
   parameter int unsigned addr_width = 4
);

   logic [data_width-1:0] A;
   logic [data_width-1:0] B;
   logic [op_width-1:0]   op;
   logic                  valid;
   logic                  ready;
   logic [addr_width-1:0] idx;

   modport master (output A, B, op, valid, idx, input ready);
   modport slave  (input A, B, op, valid, idx, output ready);

endinterface

// File: rtl/ps03_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and single-step advance.
module ps03_lfsr32
   import ps03_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seed,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] state
);

   logic [31:0] state_q;

   // Reload has priority over stepping.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         state_q <= seed;
      end else if (advance) begin
         state_q <= lfsr_step(state_q);
      end
   end

   assign state = state_q;

endmodule

// File: rtl/ps03_stimgen.sv
// Table/LFSR driven operand generator with a registered valid/ready output.
module ps03_stimgen
   import ps03_pkg::*;
#(
   parameter int unsigned data_width = 32,
   parameter int unsigned op_width   = 4,
   parameter int unsigned depth      = 16,
   parameter int unsigned addr_width = $clog2(depth),
   parameter logic [31:0] lfsr_seed  = 32'hACE1_2345
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            mode,
   input  logic                  wr_en,
   input  logic [addr_width-1:0] wr_addr,
   input  logic [data_width-1:0] wr_a,
   input  logic [data_width-1:0] wr_b,
   input  logic [op_width-1:0]   wr_op,
   ps03_stimgen_if.master        vec,
   output logic                  done,
   output logic [31:0]           vec_cnt
);

   typedef logic [data_width-1:0] data_t;

   localparam logic [addr_width-1:0] LastIdx = addr_width'(depth - 1);

   logic [data_width-1:0] tbl_a  [depth];
   logic [data_width-1:0] tbl_b  [depth];
   logic [op_width-1:0]   tbl_op [depth];

   state_e                state_q, state_d;
   mode_e                 mode_q, mode_d, mode_dec;
   logic [data_width-1:0] a_q, a_d, b_q, b_d;
   logic [op_width-1:0]   op_q, op_d;
   logic                  valid_q, valid_d;
   logic [addr_width-1:0] idx_q, idx_d, idx_nxt;
   logic                  done_q, done_d;
   logic [31:0]           cnt_q, cnt_d;

   logic [31:0] lfsr_a, lfsr_b, lfsr_a_nxt, lfsr_b_nxt;
   logic        lfsr_load, lfsr_adv;
   logic        transfer;

   ps03_lfsr32 u_lfsr_a (
      .clk     (clk),
      .rst     (rst),
      .seed    (lfsr_seed),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .state   (lfsr_a)
   );

   ps03_lfsr32 u_lfsr_b (
      .clk     (clk),
      .rst     (rst),
      .seed    (~lfsr_seed),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .state   (lfsr_b)
   );

   assign transfer   = valid_q & vec.ready;
   assign idx_nxt    = idx_q + 1'b1;
   assign mode_dec   = decode_mode(mode);
   assign lfsr_a_nxt = lfsr_step(lfsr_a);
   assign lfsr_b_nxt = lfsr_step(lfsr_b);

   // Table write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tbl_a[wr_addr]  <= wr_a;
         tbl_b[wr_addr]  <= wr_b;
         tbl_op[wr_addr] <= wr_op;
      end
   end

   // Next-state, next-vector and LFSR control.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      done_d    = done_q;
      cnt_d     = cnt_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            if (stop) begin
               state_d = StIdle;
               done_d  = 1'b0;
            end else if (start) begin
               state_d   = StRun;
               mode_d    = mode_dec;
               cnt_d     = '0;
               done_d    = 1'b0;
               valid_d   = 1'b1;
               idx_d     = '0;
               lfsr_load = 1'b1;
               // The LFSRs reload this edge, so the first random vector is the seed itself.
               if (mode_dec == MODE_RAND) begin
                  a_d  = data_t'(lfsr_seed);
                  b_d  = data_t'(~lfsr_seed);
                  op_d = lfsr_seed[31 -: op_width];
               end else begin
                  a_d  = tbl_a[0];
                  b_d  = tbl_b[0];
                  op_d = tbl_op[0];
               end
            end
         end

         StRun: begin
            if (transfer) begin
               cnt_d = cnt_q + 32'd1;
            end
            if (stop) begin
               state_d = StIdle;
               valid_d = 1'b0;
            end else if (transfer) begin
               if (mode_q == MODE_RAND) begin
                  lfsr_adv = 1'b1;
                  a_d      = data_t'(lfsr_a_nxt);
                  b_d      = data_t'(lfsr_b_nxt);
                  op_d     = lfsr_a_nxt[31 -: op_width];
                  idx_d    = '0;
               end else if (mode_q == MODE_SINGLE && idx_q == LastIdx) begin
                  state_d = StDone;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_nxt;
                  a_d   = tbl_a[idx_nxt];
                  b_d   = tbl_b[idx_nxt];
                  op_d  = tbl_op[idx_nxt];
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mode_q  <= MODE_LOOP;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign vec.A     = a_q;
   assign vec.B     = b_q;
   assign vec.op    = op_q;
   assign vec.valid = valid_q;
   assign vec.idx   = idx_q;
   assign done      = done_q;
   assign vec_cnt   = cnt_q;

endmodule

// File: tb/tb_ps03_stimgen.sv
// Directed/randomised bench for ps03_stimgen against a table and LFSR model.
module tb_ps03_stimgen;

   localparam int unsigned DW    = 32;
   localparam int unsigned OW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam logic [31:0] SEED  = 32'h0000_0001;

   logic          clk = 1'b0;
   logic          rst, start, stop, wr_en, done;
   logic [1:0]    mode;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_a, wr_b;
   logic [OW-1:0] wr_op;
   logic [31:0]   vec_cnt;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] m_a  [DEPTH];
   logic [DW-1:0] m_b  [DEPTH];
   logic [OW-1:0] m_op [DEPTH];

   ps03_stimgen_if #(.data_width(DW), .op_width(OW), .addr_width(AW)) vec ();

   ps03_stimgen #(
      .data_width (DW),
      .op_width   (OW),
      .depth      (DEPTH),
      .lfsr_seed  (SEED)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .mode    (mode),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_a    (wr_a),
      .wr_b    (wr_b),
      .wr_op   (wr_op),
      .vec     (vec),
      .done    (done),
      .vec_cnt (vec_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [1:0] m);
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic stop_run();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic write_entry(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [OW-1:0] o);
      wr_en   = 1'b1;
      wr_addr = AW'(k);
      wr_a    = a;
      wr_b    = b;
      wr_op   = o;
      tick();
      wr_en   = 1'b0;
   endtask

   function automatic logic [127:0] seen();
      return 128'({vec.valid, vec.idx, vec.A, vec.B, vec.op});
   endfunction

   // n-th table vector of a run: index n mod depth.
   function automatic logic [127:0] want(input int n);
      int i;
      i = n % DEPTH;
      return 128'({1'b1, AW'(i), m_a[i], m_b[i], m_op[i]});
   endfunction

   function automatic logic [127:0] want_rand(input logic [31:0] ra, input logic [31:0] rb);
      return 128'({1'b1, AW'(0), ra, rb, ra[31:28]});
   endfunction

   function automatic logic [31:0] galois(input logic [31:0] x);
      return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int            n;
      int            cyc;
      logic          rdy;
      logic [127:0]  old;
      logic [31:0]   ra, rb;

      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
      wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; wr_op = '0;
      vec.ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_vec", seen(), '0);
      check("reset_done", done, 1'b0);
      check("reset_cnt", vec_cnt, 32'd0);

      // Table: A = index, B and op random.
      for (int k = 0; k < DEPTH; k++) begin
         m_a[k]  = DW'(k);
         m_b[k]  = $urandom;
         m_op[k] = OW'($urandom_range(0, 15));
         write_entry(k, m_a[k], m_b[k], m_op[k]);
      end

      // Loop mode at full throughput.
      vec.ready = 1'b1;
      start_run(2'b00);
      for (int i = 0; i < 40; i++) begin
         check($sformatf("loop_vec%0d", i), seen(), want(i));
         tick();
      end
      check("loop_cnt", vec_cnt, 32'd40);
      vec.ready = 1'b0;
      stop_run();
      check("loop_stop_valid", vec.valid, 1'b0);
      check("loop_stop_cnt", vec_cnt, 32'd40);

      // Single pass under random backpressure.
      start_run(2'b01);
      n = 0;
      cyc = 0;
      while (n < DEPTH && cyc < 300) begin
         check($sformatf("single_vec%0d", n), seen(), want(n));
         rdy = 1'($urandom_range(0, 1));
         vec.ready = rdy;
         tick();
         if (rdy) n++;
         cyc++;
      end
      check("single_budget", n, DEPTH);
      check("single_done", done, 1'b1);
      check("single_valid", vec.valid, 1'b0);
      check("single_cnt", vec_cnt, 32'd16);
      vec.ready = 1'b1;
      tick();
      check("single_done_hold", done, 1'b1);

      // Restart from DONE with mode 11, which runs as a single pass.
      start_run(2'b11);
      check("m11_done_clr", done, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("m11_vec%0d", i), seen(), want(i));
         tick();
      end
      check("m11_done", done, 1'b1);
      check("m11_valid", vec.valid, 1'b0);
      check("m11_cnt", vec_cnt, 32'd16);
      stop_run();
      check("done_stop_clr", done, 1'b0);

      // Write hazard on the presented entry.
      start_run(2'b00);
      repeat (3) tick();
      vec.ready = 1'b0;
      check("haz_pre", seen(), want(3));
      old = want(3);
      write_entry(3, 32'h0000_DEAD, m_b[3], m_op[3]);
      m_a[3] = 32'h0000_DEAD;
      check("haz_hold", seen(), old);
      vec.ready = 1'b1;
      tick();
      for (int i = 4; i < 20; i++) begin
         check($sformatf("haz_vec%0d", i), seen(), want(i));
         if (i == 19) check("haz_new_a", vec.A, 32'h0000_DEAD);
         tick();
      end
      vec.ready = 1'b0;
      stop_run();

      // Stop with a simultaneous transfer at idx 5.
      vec.ready = 1'b1;
      start_run(2'b00);
      repeat (5) tick();
      check("stop_at5", seen(), want(5));
      stop_run();
      check("stop_valid", vec.valid, 1'b0);
      check("stop_cnt", vec_cnt, 32'd6);
      tick();
      check("stop_idle", vec.valid, 1'b0);

      // Reset mid-run.
      start_run(2'b00);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_vec", seen(), '0);
      check("rst_done", done, 1'b0);
      check("rst_cnt", vec_cnt, 32'd0);

      // start and stop together in IDLE.
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("ss_valid", vec.valid, 1'b0);
      tick();
      check("ss_idle", vec.valid, 1'b0);

      // start during RUN is ignored.
      start_run(2'b00);
      repeat (3) tick();
      start_run(2'b10);
      check("run_start_vec", seen(), want(4));
      check("run_start_cnt", vec_cnt, 32'd4);
      vec.ready = 1'b0;
      stop_run();

      // Random mode, twice from the same seed.
      for (int pass = 0; pass < 2; pass++) begin
         ra = SEED;
         rb = ~SEED;
         n = 0;
         cyc = 0;
         vec.ready = 1'b0;
         start_run(2'b10);
         check($sformatf("rand%0d_first_a", pass), vec.A, 32'h0000_0001);
         while (n < 20 && cyc < 300) begin
            check($sformatf("rand%0d_vec%0d", pass, n), seen(), want_rand(ra, rb));
            rdy = 1'($urandom_range(0, 1));
            vec.ready = rdy;
            tick();
            if (rdy) begin
               n++;
               ra = galois(ra);
               rb = galois(rb);
               if (n == 1) check($sformatf("rand%0d_second_a", pass), vec.A, 32'h8020_0003);
            end
            cyc++;
         end
         check($sformatf("rand%0d_budget", pass), n, 20);
         check($sformatf("rand%0d_cnt", pass), vec_cnt, 32'd20);
         vec.ready = 1'b0;
         stop_run();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps03_stimgen.md
Name: ps03_stimgen

Overview:
- Parametrised stimulus generator that drives operand A, operand B and opcode into an ALU or datapath under test.
- Vectors come from a writable on-chip table, sequenced in loop or single-pass mode, or from a built-in pseudo-random source.
- Output is a registered valid/ready stream, so a stalling DUT or checker can throttle it. A handshake counter supports run-length bookkeeping.

Parameters:
- data_width, 32, width of A, B and the table data fields
- op_width, 4, width of op and the table op field
- depth, 16, number of table entries; must be a power of 2, at least 2
- addr_width, $clog2(depth), table index width (derived, not overridden)
- lfsr_seed, 32'hACE1_2345, seed for the random source; must be nonzero

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- stop  in  1  single-cycle pulse; aborts a run
- mode  in  2  00 loop, 01 single pass, 10 random, 11 treated as 01; sampled only when start is accepted
- wr_en  in  1  table write strobe
- wr_addr  in  addr_width  table write index
- wr_a  in  data_width  A value to store
- wr_b  in  data_width  B value to store
- wr_op  in  op_width  op value to store
- A  out  data_width  operand A (registered)
- B  out  data_width  operand B (registered)
- op  out  op_width  opcode (registered)
- valid  out  1  A/B/op hold a vector
- ready  in  1  consumer accepts the vector this cycle
- idx  out  addr_width  table index of the presented vector; 0 in random mode
- done  out  1  single-pass run completed
- vec_cnt  out  32  accepted handshakes since the last start; wraps modulo 2^32

Behaviour:
- Reset values: A=0, B=0, op=0, valid=0, idx=0, done=0, vec_cnt=0, state=IDLE, both LFSRs reloaded. Table contents are not reset.
- Reset mid-run: returns to IDLE on the next edge. Any presented vector is dropped with no handshake.
- Table write port:
  - Writes take effect at the clock edge and are legal in any state.
  - A write to the entry currently presented does not change A/B/op. Only later loads see the new data.
- Handshake:
  - Transfer occurs when valid=1 and ready=1.
  - While valid=1 and ready=0, A/B/op/idx hold stable.
  - valid never drops without a transfer, except on stop or rst.
- State machine: IDLE, RUN, DONE.
  - IDLE, start=1: latch mode, clear vec_cnt, load entry 0 (or the LFSR outputs), valid=1 on the next cycle, go to RUN. Latency is start to first valid = 1 cycle.
  - RUN, transfer: vec_cnt+1. Next cycle presents the next vector with no bubble, giving 1 vector per cycle at full throughput.
  - Loop mode: idx runs depth-1 -> 0 and continues indefinitely.
  - Single-pass mode: a transfer at idx=depth-1 goes to DONE with valid=0 and done=1 the next cycle.
  - Random mode: each transfer advances both LFSRs one step. No end condition.
  - RUN, stop=1: go to IDLE, valid=0 next cycle. stop wins over a simultaneous transfer; vec_cnt still counts that transfer.
  - RUN, start=1: ignored.
  - DONE: done stays high. start restarts exactly as from IDLE and clears done. stop goes to IDLE and clears done.
  - IDLE or DONE, stop=1: no effect beyond the DONE-to-IDLE move above.
  - start and stop in the same cycle: stop wins.
- Random source:
  - Two 32-bit Galois LFSRs, polynomial x^32+x^22+x^2+x+1. lfsr_a is seeded lfsr_seed, lfsr_b is seeded ~lfsr_seed.
  - A = lfsr_a, B = lfsr_b: truncated to low bits if data_width<32, zero-extended if data_width>32.
  - op = lfsr_a[31 -: op_width].
  - Each LFSR reloads its seed on rst and on an accepted start.
- Width rules:
  - vec_cnt wraps silently.
  - idx wraps modulo depth.
  - Table reads are asynchronous from the register array into the output registers.

Decomposition:
- Package ps03_pkg:
  - mode encodings MODE_LOOP, MODE_SINGLE, MODE_RAND
  - state encoding
  - LFSR polynomial constant LFSR_POLY = 32'h8020_0003
- One sub-module, ps03_lfsr32: seed, load, advance inputs and a 32-bit state output. Instantiated twice.
- The table is inferred inside the top module.

Test Plan:
- Loop mode, depth 16: write entry k = {A=k, B=100+k, op=k}, start mode=00, ready=1 -> 40 consecutive vectors, idx 0..15,0..15,0..7, A=idx, no bubbles, vec_cnt=40.
- Single pass with backpressure: ready toggling 1,0,0,1,... -> values stable while ready=0, exactly 16 transfers, done=1 one cycle after the last, valid=0; a later start clears done and restarts at idx 0.
- Stop and reset mid-run: stop at idx 5 with ready=1 -> vec_cnt=6, IDLE, valid=0 next cycle; repeat using rst instead of stop -> all outputs 0 next cycle.
- Random mode, lfsr_seed 1: first A=32'h0000_0001, second A=32'h8020_0003 after one transfer; restart reproduces the identical sequence; op equals A[31:28].
- Write hazard: with entry 3 presented and ready=0, write entry 3 to A=32'hDEAD -> presented A unchanged; the next loop pass shows 32'hDEAD at idx 3.
- Edge inputs: start and stop in the same IDLE cycle -> stays IDLE; start during RUN -> ignored, sequence uninterrupted; mode=11 -> behaves as single pass.
